// File: rtl/led_sequencer_if.sv
// Control and LED-drive bundle for led_sequencer.
// The master drives the sequencing controls; the slave (the sequencer) drives the pins and the step strobe.
interface led_sequencer_if #(
  parameter int N_LED    = 3,
  parameter int PWM_BITS = 8
);
  logic                enable;
  logic [1:0]          mode;
  logic [PWM_BITS-1:0] brightness;
  logic                step_pulse;
  logic [N_LED-1:0]    led;

  modport master (output enable, mode, brightness, input step_pulse, led);
  modport slave  (input enable, mode, brightness, output step_pulse, led);
endinterface

// File: rtl/led_sequencer.sv
// LED pattern sequencer: a prescaled step tick advances a rotate, ping-pong or blink pattern.
// A global PWM duty gates every channel before it reaches the registered pins.
module led_sequencer #(
  parameter int N_LED       = 3,
  parameter int STEP_CYCLES = 13500000,
  parameter int PWM_BITS    = 8,
  parameter int ACTIVE_LOW  = 1
) (
  input logic             sys_clk,
  input logic             sys_rst,
  led_sequencer_if.slave  bus
);

  localparam int CW = $clog2(STEP_CYCLES);
  localparam int PW = (N_LED > 1) ? $clog2(N_LED) : 1;
  localparam logic [CW-1:0]    PRESC_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [PW-1:0]    POS_LAST   = PW'(N_LED - 1);
  localparam logic [N_LED-1:0] LED_OFF    = {N_LED{ACTIVE_LOW != 0}};

  typedef enum logic [1:0] {
    MODE_ROT_UP = 2'b00,
    MODE_ROT_DN = 2'b01,
    MODE_PING   = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  logic [CW-1:0]       presc_q;
  logic [PWM_BITS-1:0] pwm_q;
  logic [PW-1:0]       pos_q, pos_d;
  dir_e                dir_q, dir_d;
  logic                ph_q, ph_d;
  mode_e               mode_q;
  logic                step_q;
  logic [N_LED-1:0]    led_q;

  logic                tick;
  logic                duty_on;
  logic                ping_up;
  logic [PW-1:0]       pos_inc, pos_dec;
  logic [N_LED-1:0]    pattern;
  logic [N_LED-1:0]    lit;

  assign tick    = bus.enable && (presc_q == PRESC_LAST);
  assign pos_inc = pos_q + PW'(1);
  assign pos_dec = pos_q - PW'(1);

  // Endpoints override the stored direction so entering ping-pong at an edge heads inward.
  assign ping_up = (pos_q == '0) || ((pos_q != POS_LAST) && (dir_q == DIR_UP));

  // The displayed pattern follows the mode latched at the last tick, not the live input.
  assign pattern = (mode_q == MODE_BLINK) ? {N_LED{ph_q}} : (N_LED'(1) << pos_q);
  assign duty_on = (pwm_q < bus.brightness) || (bus.brightness == '1);
  assign lit     = pattern & {N_LED{duty_on}};

  // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    ph_d  = ph_q;
    case (mode_e'(bus.mode))
      MODE_ROT_UP: pos_d = (pos_q == POS_LAST) ? '0 : pos_inc;
      MODE_ROT_DN: pos_d = (pos_q == '0) ? POS_LAST : pos_dec;
      MODE_PING: begin
        if (N_LED > 1) begin
          if (ping_up) begin
            pos_d = pos_inc;
            dir_d = (pos_inc == POS_LAST) ? DIR_DOWN : DIR_UP;
          end else begin
            pos_d = pos_dec;
            dir_d = (pos_dec == '0) ? DIR_UP : DIR_DOWN;
          end
        end
      end
      default: ph_d = ~ph_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      presc_q <= '0;
      pwm_q   <= '0;
      pos_q   <= '0;
      dir_q   <= DIR_UP;
      ph_q    <= 1'b0;
      mode_q  <= MODE_ROT_UP;
      step_q  <= 1'b0;
      led_q   <= LED_OFF;
    end else begin
      pwm_q  <= pwm_q + PWM_BITS'(1);
      step_q <= tick;
      led_q  <= (ACTIVE_LOW != 0) ? ~lit : lit;
      if (bus.enable) begin
        presc_q <= tick ? '0 : presc_q + CW'(1);
      end
      if (tick) begin
        mode_q <= mode_e'(bus.mode);
        pos_q  <= pos_d;
        dir_q  <= dir_d;
        ph_q   <= ph_d;
      end
    end
  end

  assign bus.step_pulse = step_q;
  assign bus.led        = led_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Randomized bench for led_sequencer against a cycle-level behavioural model.
// Ping-pong is modelled as a phase on a bounce cycle of length 2*(N_LED-1).
module tb_led_sequencer;

  localparam int N_LED       = 3;
  localparam int STEP_CYCLES = 4;
  localparam int PWM_BITS    = 2;
  localparam int ACTIVE_LOW  = 1;
  localparam int PWM_MAX     = (1 << PWM_BITS) - 1;
  localparam int ALL         = (1 << N_LED) - 1;
  localparam int LED_OFF     = ACTIVE_LOW ? ALL : 0;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  led_sequencer_if #(.N_LED(N_LED), .PWM_BITS(PWM_BITS)) bus ();

  led_sequencer #(
    .N_LED(N_LED), .STEP_CYCLES(STEP_CYCLES), .PWM_BITS(PWM_BITS), .ACTIVE_LOW(ACTIVE_LOW)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus(bus)
  );

  always #5 sys_clk = ~sys_clk;

  // Model state: prescale count, pwm count, position, heading-down flag, blink phase, shown mode.
  int m_cnt, m_pwm, m_pos, m_ph, m_mode;
  bit m_dn;
  int exp_led;
  int exp_step;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_pwm = 0; m_pos = 0; m_ph = 0; m_mode = 0; m_dn = 1'b0;
    exp_led = LED_OFF; exp_step = 0;
  endtask

  task automatic model_edge();
    int pat, lit, bri, span, k;
    bit tick;
    if (sys_rst) begin
      model_reset();
      return;
    end
    bri = int'(bus.brightness);
    pat = (m_mode == 3) ? (m_ph ? ALL : 0) : (1 << m_pos);
    lit = (bri == PWM_MAX || m_pwm < bri) ? pat : 0;
    exp_led = ACTIVE_LOW ? (~lit & ALL) : lit;
    tick = bus.enable && (m_cnt == STEP_CYCLES - 1);
    exp_step = tick ? 1 : 0;
    if (tick) begin
      m_mode = int'(bus.mode);
      case (m_mode)
        0: m_pos = (m_pos + 1) % N_LED;
        1: m_pos = (m_pos + N_LED - 1) % N_LED;
        2: if (N_LED > 1) begin
             span  = 2 * N_LED - 2;
             k     = m_dn ? (span - m_pos) % span : m_pos;
             k     = (k + 1) % span;
             m_pos = (k < N_LED) ? k : span - k;
             m_dn  = (k >= N_LED - 1);
           end
        default: m_ph = 1 - m_ph;
      endcase
    end
    if (bus.enable) m_cnt = tick ? 0 : m_cnt + 1;
    m_pwm = (m_pwm + 1) % (PWM_MAX + 1);
  endtask

  task automatic cycle();
    @(posedge sys_clk);
    model_edge();
    #1;
    check("led", int'(bus.led), exp_led);
    check("step_pulse", int'(bus.step_pulse), exp_step);
  endtask

  // Asynchronous reset pulse landing mid-cycle; the pins must go dark before any edge.
  task automatic do_reset();
    #3 sys_rst = 1'b1;
    #1;
    check("rst_async_led", int'(bus.led), LED_OFF);
    check("rst_async_step", int'(bus.step_pulse), 0);
    model_reset();
    cycle();
    sys_rst = 1'b0;
  endtask

  initial begin
    bit seen;
    bus.enable     = 1'b0;
    bus.mode       = 2'b00;
    bus.brightness = PWM_BITS'(PWM_MAX);
    model_reset();

    #2 sys_rst = 1'b1;
    #1;
    check("rst_led", int'(bus.led), LED_OFF);
    check("rst_step", int'(bus.step_pulse), 0);
    repeat (2) cycle();
    sys_rst = 1'b0;

    // Held idle after release: bit 0 lit at full duty.
    cycle();
    check("idle_led", int'(bus.led), 3'b110);
    repeat (3) cycle();

    // Rotate-up at full brightness.
    bus.enable = 1'b1;
    repeat (20) cycle();

    // Ping-pong straight from reset.
    do_reset();
    bus.mode = 2'b10;
    repeat (28) cycle();

    // Partial and zero duty.
    bus.mode = 2'b00;
    bus.brightness = PWM_BITS'(1);
    repeat (16) cycle();
    bus.brightness = '0;
    repeat (12) cycle();

    // All-blink.
    bus.brightness = PWM_BITS'(PWM_MAX);
    bus.mode = 2'b11;
    repeat (20) cycle();

    // Enable dropped mid-step for ten cycles.
    bus.mode = 2'b00;
    repeat (2) cycle();
    bus.enable = 1'b0;
    repeat (10) cycle();
    bus.enable = 1'b1;
    repeat (10) cycle();

    // Switch to rotate-down just after a step strobe.
    seen = 1'b0;
    for (int i = 0; i < 2 * STEP_CYCLES && !seen; i++) begin
      cycle();
      seen = (exp_step == 1);
    end
    check("strobe_seen", int'(seen), 1);
    bus.mode = 2'b01;
    repeat (16) cycle();

    // Ping-pong entered from an arbitrary position after rotation.
    bus.mode = 2'b10;
    repeat (24) cycle();

    for (int i = 0; i < 900; i++) begin
      bus.enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) bus.brightness = PWM_BITS'($urandom_range(0, PWM_MAX));
      if ($urandom_range(0, 199) == 0) do_reset();
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
